// File: rtl/fifo_pkt_writer.sv
// Frames a byte stream into header/payload/trailer words for the async FIFO write port.
// The header is written 1 cycle after s_valid in IDLE. fifo_full stalls any write state with no write; DROP always accepts.
module fifo_pkt_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LEN    = 16,
  parameter int LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  output logic                  busy,
  output logic                  trunc_err,
  output logic [15:0]           pkt_cnt
);

  typedef enum logic [2:0] {IDLE, HDR, DATA, TRL, DROP} state_t;

  localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(MAX_LEN - 1);

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] seq, seq_nxt;
  logic [DATA_WIDTH-1:0] csum, csum_nxt;
  logic [LEN_W-1:0]      len, len_nxt;
  logic                  trunc_pend, trunc_pend_nxt;
  logic [15:0]           pkt_cnt_nxt;
  logic                  data_hs;

  assign data_hs = s_valid && !fifo_full;
  assign busy    = (state != IDLE);

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state      <= IDLE;
      seq        <= '0;
      csum       <= '0;
      len        <= '0;
      trunc_pend <= 1'b0;
      pkt_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      seq        <= seq_nxt;
      csum       <= csum_nxt;
      len        <= len_nxt;
      trunc_pend <= trunc_pend_nxt;
      pkt_cnt    <= pkt_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    seq_nxt        = seq;
    csum_nxt       = csum;
    len_nxt        = len;
    trunc_pend_nxt = trunc_pend;
    pkt_cnt_nxt    = pkt_cnt;
    s_ready        = 1'b0;
    fifo_wr_en     = 1'b0;
    fifo_wr_data   = '0;
    trunc_err      = 1'b0;

    case (state)
      IDLE: begin
        if (s_valid) state_nxt = HDR;
      end
      HDR: begin
        if (!fifo_full) begin
          fifo_wr_en   = 1'b1;
          fifo_wr_data = seq;
          csum_nxt     = seq;
          len_nxt      = '0;
          state_nxt    = DATA;
        end
      end
      DATA: begin
        s_ready      = !fifo_full;
        fifo_wr_en   = data_hs;
        fifo_wr_data = s_data;
        if (data_hs) begin
          csum_nxt = csum ^ s_data;
          len_nxt  = len + 1'b1;
          if (s_last) begin
            state_nxt = TRL;
          end else if (len == LEN_LAST) begin
            // MAX_LEN-th beat without s_last: close the frame and swallow the rest
            trunc_pend_nxt = 1'b1;
            trunc_err      = 1'b1;
            state_nxt      = TRL;
          end
        end
      end
      TRL: begin
        if (!fifo_full) begin
          fifo_wr_en   = 1'b1;
          fifo_wr_data = csum;
          seq_nxt      = seq + 1'b1;
          pkt_cnt_nxt  = pkt_cnt + 16'd1;
          state_nxt    = trunc_pend ? DROP : IDLE;
        end
      end
      DROP: begin
        s_ready = 1'b1;
        if (s_valid && s_last) begin
          trunc_pend_nxt = 1'b0;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_pkt_writer.sv
// Randomized bench for fifo_pkt_writer: packets are expanded into expected FIFO words by a queue model.
module tb_fifo_pkt_writer;
  localparam int DW = 8;
  localparam int ML = 16;

  logic          wr_clk = 1'b0;
  logic          wr_rst_n;
  logic          s_valid, s_ready, s_last;
  logic [DW-1:0] s_data;
  logic          fifo_full = 1'b0;
  logic          fifo_wr_en, busy, trunc_err;
  logic [DW-1:0] fifo_wr_data;
  logic [15:0]   pkt_cnt;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int stall_cnt = 0;
  bit rand_full = 1'b0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] seq_m = '0;
  int            pkts_m = 0;
  logic [DW-1:0] pkt_dat[64];

  fifo_pkt_writer #(.DATA_WIDTH(DW), .MAX_LEN(ML)) dut (
    .wr_clk(wr_clk), .wr_rst_n(wr_rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .busy(busy), .trunc_err(trunc_err), .pkt_cnt(pkt_cnt)
  );

  always #5 wr_clk = ~wr_clk;
  always @(posedge wr_clk) cyc++;

  always @(posedge wr_clk) begin
    #1;
    if (stall_cnt > 0) begin
      fifo_full = 1'b1;
      stall_cnt--;
    end else begin
      fifo_full = rand_full ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Every FIFO write is matched against the next expected word in order
  always @(negedge wr_clk) begin
    if (wr_rst_n) begin
      if (fifo_full && busy) chk("wr_while_full", fifo_wr_en, 0);
      if (fifo_wr_en) begin
        if (exp_q.size() == 0) chk("unexpected_wr", exp_q.size(), 1);
        else chk("wr_data", fifo_wr_data, exp_q.pop_front());
      end
    end
  end

  task automatic fill_rand();
    for (int i = 0; i < 64; i++) pkt_dat[i] = DW'($urandom);
  endtask

  task automatic drive_beat(input logic [DW-1:0] d, input logic l, input logic exp_tr);
    int t = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    @(negedge wr_clk);
    while (!s_ready && t < 300) begin
      t++;
      @(negedge wr_clk);
    end
    chk("beat_accept", s_ready, 1);
    chk("trunc_err", trunc_err, exp_tr);
    @(posedge wr_clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge wr_clk);
    while (busy && t < 300) begin
      t++;
      @(negedge wr_clk);
    end
    chk("idle", busy, 0);
    chk("all_words_written", exp_q.size(), 0);
  endtask

  task automatic send_pkt(input int n);
    logic [DW-1:0] x;
    int k;
    k = (n > ML) ? ML : n;
    x = seq_m;
    exp_q.push_back(seq_m);
    for (int i = 0; i < k; i++) begin
      exp_q.push_back(pkt_dat[i]);
      x ^= pkt_dat[i];
    end
    exp_q.push_back(x);
    seq_m++;
    pkts_m++;
    for (int i = 0; i < n; i++) drive_beat(pkt_dat[i], i == n - 1, (n > ML) && (i == ML - 1));
    wait_idle();
    chk("pkt_cnt", pkt_cnt, pkts_m[15:0]);
  endtask

  task automatic do_reset();
    @(negedge wr_clk);
    wr_rst_n = 1'b0;
    exp_q.delete();
    seq_m  = '0;
    pkts_m = 0;
    @(negedge wr_clk);
    wr_rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, h, t;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; wr_rst_n = 1'b0;
    repeat (3) @(posedge wr_clk);
    @(negedge wr_clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_wr_data", fifo_wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_trunc_err", trunc_err, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    wr_rst_n = 1'b1;

    // 4-beat packet, no back-pressure, IDLE-to-IDLE cycle count
    @(posedge wr_clk); #1;
    c0 = cyc;
    pkt_dat[0] = 8'h11; pkt_dat[1] = 8'h22; pkt_dat[2] = 8'h33; pkt_dat[3] = 8'h44;
    send_pkt(4);
    chk("pkt4_cycles", cyc - c0, 7);

    pkt_dat[0] = 8'hA5; send_pkt(1);
    pkt_dat[0] = 8'h5A; send_pkt(1);

    // 5-cycle stall in the middle of an 8-beat packet
    fill_rand();
    fork
      send_pkt(8);
      begin
        h = 0; t = 0;
        while (h < 2 && t < 200) begin
          @(negedge wr_clk);
          if (s_valid && s_ready) h++;
          t++;
        end
        stall_cnt = 5;
        @(posedge wr_clk); #2;
        repeat (5) begin
          @(negedge wr_clk);
          chk("stall_s_ready", s_ready, 0);
          chk("stall_wr_en", fifo_wr_en, 0);
        end
      end
    join

    // truncation at MAX_LEN, then the next header must be 0x01
    do_reset();
    fill_rand(); send_pkt(20);
    fill_rand(); send_pkt(2);

    // reset during DATA after 3 beats, with a 4th beat being written
    fill_rand();
    exp_q.push_back(seq_m);
    for (int i = 0; i < 3; i++) exp_q.push_back(pkt_dat[i]);
    for (int i = 0; i < 3; i++) drive_beat(pkt_dat[i], 1'b0, 1'b0);
    s_valid = 1'b1; s_data = pkt_dat[3]; s_last = 1'b0;
    #1;
    chk("pre_rst_wr_en", fifo_wr_en, 1);
    wr_rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", fifo_wr_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_s_ready", s_ready, 0);
    chk("mid_rst_pkt_cnt", pkt_cnt, 0);
    chk("mid_rst_words", exp_q.size(), 0);
    s_valid = 1'b0;
    seq_m = '0;
    pkts_m = 0;
    @(negedge wr_clk);
    wr_rst_n = 1'b1;
    fill_rand(); send_pkt(3);

    // 256 single-beat packets with random back-pressure: sequence wraps
    do_reset();
    rand_full = 1'b1;
    for (int p = 0; p < 256; p++) begin
      pkt_dat[0] = DW'($urandom);
      send_pkt(1);
    end
    chk("pkt_cnt_256", pkt_cnt, 256);

    // random lengths, including truncated ones
    for (int p = 0; p < 40; p++) begin
      repeat ($urandom_range(0, 2)) @(negedge wr_clk);
      fill_rand();
      send_pkt($urandom_range(1, 24));
    end
    rand_full = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
